// File: rtl/dds_dual_nco_sched.sv
// Two-channel NCO sequencer sharing one negedge-read sine BRAM between both channels.
// Optional feature macro: DDS_PHASE_OFFSET_EN adds per-channel phase offset registers.
module dds_dual_nco_sched #(
    parameter int DATA_W           = 16,
    parameter int ACC_W            = 24,
    parameter int SAMPLE_ADDR_BITS = 8
) (
    input  logic                        dds_clk,
    input  logic                        dds_rst,
    input  logic                        sample_tick,
    input  logic                        phase_clr,
    input  logic                        cfg_wr,
    input  logic [1:0]                  cfg_addr,
    input  logic [ACC_W-1:0]            cfg_data,
    output logic                        bram_ce,
    output logic [SAMPLE_ADDR_BITS-1:0] bram_addr,
    input  logic [DATA_W-1:0]           bram_data,
    output logic [DATA_W-1:0]           ch0_out,
    output logic                        ch0_valid,
    output logic [DATA_W-1:0]           ch1_out,
    output logic                        ch1_valid,
    output logic                        busy,
    output logic                        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1
    } state_t;

    state_t state;

    logic [ACC_W-1:0] phase0, phase1;
    logic [ACC_W-1:0] ftw0, ftw1;
    logic [ACC_W-1:0] ftw0_sh, ftw1_sh;
    logic [ACC_W-1:0] sum0, sum1;

`ifdef DDS_PHASE_OFFSET_EN
    logic [ACC_W-1:0] off0, off1;
    logic [ACC_W-1:0] off0_sh, off1_sh;
`endif

    // ch0 address is formed in IDLE at the tick, so it sees the cleared phase and the offset being committed
    always_comb begin
        sum0 = phase_clr ? '0 : phase0;
        sum1 = phase1;
`ifdef DDS_PHASE_OFFSET_EN
        sum0 = sum0 + off0_sh;
        sum1 = sum1 + off1;
`endif
    end

    always_ff @(posedge dds_clk) begin
        if (dds_rst) begin
            ftw0_sh <= '0;
            ftw1_sh <= '0;
`ifdef DDS_PHASE_OFFSET_EN
            off0_sh <= '0;
            off1_sh <= '0;
`endif
        end else if (cfg_wr) begin
            case (cfg_addr)
                2'd0: ftw0_sh <= cfg_data;
                2'd1: ftw1_sh <= cfg_data;
`ifdef DDS_PHASE_OFFSET_EN
                2'd2: off0_sh <= cfg_data;
                2'd3: off1_sh <= cfg_data;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge dds_clk) begin
        if (dds_rst) begin
            state     <= IDLE;
            phase0    <= '0;
            phase1    <= '0;
            ftw0      <= '0;
            ftw1      <= '0;
`ifdef DDS_PHASE_OFFSET_EN
            off0      <= '0;
            off1      <= '0;
`endif
            bram_ce   <= 1'b0;
            bram_addr <= '0;
            ch0_out   <= '0;
            ch0_valid <= 1'b0;
            ch1_out   <= '0;
            ch1_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            ch0_valid <= 1'b0;
            ch1_valid <= 1'b0;
            if (sample_tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        ftw0 <= ftw0_sh;
                        ftw1 <= ftw1_sh;
`ifdef DDS_PHASE_OFFSET_EN
                        off0 <= off0_sh;
                        off1 <= off1_sh;
`endif
                        if (phase_clr) begin
                            phase0 <= '0;
                            phase1 <= '0;
                        end
                        bram_addr <= sum0[ACC_W-1 -: SAMPLE_ADDR_BITS];
                        bram_ce   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RD0;
                    end
                end
                RD0: begin
                    ch0_out   <= bram_data;
                    ch0_valid <= 1'b1;
                    bram_addr <= sum1[ACC_W-1 -: SAMPLE_ADDR_BITS];
                    state     <= RD1;
                end
                RD1: begin
                    ch1_out   <= bram_data;
                    ch1_valid <= 1'b1;
                    bram_ce   <= 1'b0;
                    busy      <= 1'b0;
                    phase0    <= phase0 + ftw0;
                    phase1    <= phase1 + ftw1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
